data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the processor's LOAD/STORE traffic. The processor's ALU produces a byte address; this block receives a request, inserts programmable wait states, performs a 16-bit word read or write on its internal array, and returns a response.
- Sits between the core's load/store path and data storage.
- Uses a valid/ready handshake on both request and response channels.

Parameters:
- DEPTH_WORDS, 256: number of 16-bit words in the array (power of 2, 2..32768).
- WAIT_CYCLES, 2: wait states between request acceptance and the array access (0..15).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- clk_en  input  1  global stall; when low, all state holds.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = STORE, 0 = LOAD.
- req_addr  input  16  byte address.
- req_wdata  input  16  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  core accepts the response.
- resp_rdata  output  16  load data; 0 for stores and errors.
- resp_error  output  1  misaligned or out-of-range access.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - state=IDLE, wait counter=0.
  - resp_valid=0, resp_rdata=0, resp_error=0, busy=0.
  - req_ready=1 once reset_n is high.
  - Array contents are NOT cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On a clk edge with clk_en & req_valid: latch write, addr and wdata; load counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise access immediately and go to RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements on each clk_en edge.
  - On the edge where the counter is 1: perform the access and go to RESP.
- Access rules:
  - word index = addr[15:1].
  - Error if addr[0]=1 or index ≥ DEPTH_WORDS. On error: no write, rdata=0, error=1.
  - Write: array[index] = wdata, committed on the WAIT→RESP (or IDLE→RESP) edge; rdata=0.
  - Read: rdata = array[index] as of that edge.
- RESP:
  - resp_valid=1; rdata and error are held stable.
  - On an edge with clk_en & resp_ready: go to IDLE and clear resp_valid, resp_rdata and resp_error.
  - No new request is accepted in the same cycle; at most one transaction is outstanding.
- Latency (clk_en held high): accept edge to resp_valid high = WAIT_CYCLES+1 edges. Minimum turnaround is WAIT_CYCLES+2 cycles per transaction.
- clk_en=0: state, counter and outputs hold. Handshakes on that edge are not recognised.
- Reset mid-operation:
  - In WAIT: the transaction is aborted and the store is NOT committed.
  - In RESP: the committed store stays committed; the response is dropped.
- Simultaneous events: req_valid is ignored outside IDLE. resp_ready is ignored outside RESP.
- Back-to-back: a load from a just-stored address returns the new data.

Decomposition:
- Shared package data_mem_pkg:
  - State encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10).
  - WORD_BYTES=2.
  - Wait-counter width constant (4 bits).
- Sub-module data_mem_array: single-port synchronous word array.
  - Inputs: clk, we, index, wdata. Output: rdata.
  - No reset.
  - The FSM lives in data_mem_responder.

Test Plan:
- WAIT_CYCLES=2, store addr 16'h0010 data 16'hBEEF, resp_ready=1:
  - req_ready drops the cycle after acceptance.
  - resp_valid rises 3 edges after acceptance with resp_error=0 and resp_rdata=0.
  - Then load 16'h0010 returns resp_rdata=16'hBEEF.
- Load 16'h0011:
  - resp_error=1, resp_rdata=0.
  - A following load of 16'h0010 still returns 16'hBEEF.
- DEPTH_WORDS=256, store to 16'h0200 (index 256):
  - resp_error=1.
  - Load 16'h0000 is unchanged (0 after preload).
- Hold resp_ready=0 for 5 cycles in RESP:
  - resp_valid and data stay stable; req_valid pulses are not accepted (req_ready=0).
  - After resp_ready=1, the block returns to IDLE.
- Drop clk_en for 3 cycles during WAIT:
  - Latency grows by exactly 3 cycles.
  - Response data is correct.
- Assert reset_n=0 mid-WAIT of store 16'h0004←16'h1234:
  - All outputs go to 0 immediately and busy=0.
  - A later load of 16'h0004 returns the prior value, not 16'h1234.
- WAIT_CYCLES=0: response arrives 1 edge after acceptance.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the load/store data-memory responder.
package data_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam int WORD_BYTES = 2;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/data_mem_array.sv
// Single-port word array: write commits on the clock edge, read is combinational
// so the responder can capture load data on the same edge it commits a store.
module data_mem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] index,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[index] <= wdata;
  end

  assign rdata = mem[index];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one LOAD/STORE, inserts WAIT_CYCLES wait states,
// accesses the word array and holds the response until the core takes it.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_error,
  output logic        busy,
  output state_t      state_dbg
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Handshake: a transfer happens on a rising edge where clk_en, valid and ready
  // are all high; req_ready is high only in IDLE, resp_valid only in RESP.

  // Reset asserts asynchronously and releases two edges after reset_n rises.
  logic [1:0] rst_pipe;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_sync_n = rst_pipe[1];

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             write_q;
  logic [15:0]      addr_q;
  logic [15:0]      wdata_q;

  logic             in_idle;
  logic             access;
  logic             acc_write;
  logic [15:0]      acc_addr;
  logic [15:0]      acc_wdata;
  logic             acc_error;
  logic [15:0]      arr_rdata;
  logic [15:0]      acc_rdata;
  logic             arr_we;

  assign in_idle = (state == ST_IDLE);

  // With no wait states the access uses the live request on the accept edge.
  assign acc_write = in_idle ? req_write : write_q;
  assign acc_addr  = in_idle ? req_addr  : addr_q;
  assign acc_wdata = in_idle ? req_wdata : wdata_q;

  assign access = ((WAIT_CYCLES == 0) && clk_en && in_idle && req_valid) ||
                  (clk_en && (state == ST_WAIT) && (cnt == CNT_W'(1)));

  assign acc_error = acc_addr[0] || ({17'd0, acc_addr[15:1]} >= DEPTH_WORDS);
  assign arr_we    = access && acc_write && !acc_error && rst_sync_n;
  assign acc_rdata = (acc_error || acc_write) ? 16'h0000 : arr_rdata;

  data_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .index(acc_addr[AW:1]),
    .wdata(acc_wdata),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else if (clk_en) begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= CNT_W'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= acc_rdata;
              resp_error <= acc_error;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= acc_rdata;
            resp_error <= acc_error;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = rst_sync_n && in_idle;
  assign busy      = !in_idle;
  assign state_dbg = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// traffic checked against a word-level memory model.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int WAITS = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic        req_valid, req_write, resp_ready;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_error, busy;
  logic [15:0] resp_rdata;
  state_t      state_dbg;

  logic        z_clk_en, z_req_valid, z_req_write, z_resp_ready;
  logic [15:0] z_req_addr, z_req_wdata;
  logic        z_req_ready, z_resp_valid, z_resp_error, z_busy;
  logic [15:0] z_resp_rdata;
  state_t      z_state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model_mem [int];
  logic [15:0] exp_q[$];
  logic        exp_err_q[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) u_dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .busy(busy), .state_dbg(state_dbg)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .clk_en(z_clk_en),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata),
    .resp_error(z_resp_error), .busy(z_busy), .state_dbg(z_state_dbg)
  );

  // Reference: errors for odd or out-of-range addresses, stores update the
  // word map and answer 0, loads answer the last stored word.
  function automatic void model_push(input logic wr, input logic [15:0] addr,
                                     input logic [15:0] wd);
    int  idx;
    logic err;
    idx = int'(addr) / WORD_BYTES;
    err = (addr % 2 != 0) || (idx >= DEPTH);
    exp_err_q.push_back(err);
    if (err || wr) exp_q.push_back(16'h0000);
    else           exp_q.push_back(model_mem.exists(idx) ? model_mem[idx] : 16'h0000);
    if (wr && !err) model_mem[idx] = wd;
  endfunction

  // Drivers: all tasks start and end 1 time unit after a rising edge.
  task automatic send_req(input logic wr, input logic [15:0] addr, input logic [15:0] wd);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int stall_len, output int lat, output logic timeout);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      clk_en = (lat <= stall_len) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    clk_en  = 1'b1;
    timeout = !resp_valid;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                        input int stall_len, output logic [15:0] rd, output logic er,
                        output int lat, output logic timeout);
    send_req(wr, addr, wd);
    wait_resp(stall_len, lat, timeout);
    rd = resp_rdata;
    er = resp_error;
    finish_resp();
  endtask

  // Runs one transaction and checks it against the scoreboard head.
  task automatic checked_txn(input string name, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wd, input int stall_len);
    logic [15:0] rd, exp_d;
    logic er, to, exp_e;
    int lat;
    model_push(wr, addr, wd);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s req_ready before accept: got %b want 1", name, req_ready);
    end
    do_txn(wr, addr, wd, stall_len, rd, er, lat, to);
    exp_d = exp_q.pop_front();
    exp_e = exp_err_q.pop_front();
    n_checks++;
    if (to) begin
      n_fail++; $display("FAIL %s timeout waiting for resp_valid", name);
    end
    n_checks++;
    if (lat != WAITS + 1 + stall_len) begin
      n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, WAITS + 1 + stall_len);
    end
    n_checks++;
    if (rd !== exp_d || er !== exp_e) begin
      n_fail++;
      $display("FAIL %s addr %h: got rdata %h err %b want rdata %h err %b",
               name, addr, rd, er, exp_d, exp_e);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clk_en = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    z_clk_en = 1'b1; z_req_valid = 1'b0; z_req_write = 1'b0;
    z_req_addr = '0; z_req_wdata = '0; z_resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 16'h0 || resp_error !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got valid %b rdata %h err %b busy %b want 0 0 0 0",
               resp_valid, resp_rdata, resp_error, busy);
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset release: got req_ready %b busy %b want 1 0", req_ready, busy);
    end
  endtask

  task automatic preload();
    logic [15:0] rd; logic er, to; int lat;
    for (int i = 0; i < 16; i++) begin
      model_push(1'b1, 16'(i * 2), 16'h0000);
      do_txn(1'b1, 16'(i * 2), 16'h0000, 0, rd, er, lat, to);
      void'(exp_q.pop_front());
      void'(exp_err_q.pop_front());
    end
  endtask

  task automatic test_store_load();
    logic [15:0] rd; logic er, to; int lat;
    model_push(1'b1, 16'h0010, 16'hBEEF);
    send_req(1'b1, 16'h0010, 16'hBEEF);
    n_checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL store ready drop: got req_ready %b busy %b want 0 1", req_ready, busy);
    end
    wait_resp(0, lat, to);
    n_checks++;
    if (to || lat != 3 || resp_error !== exp_err_q.pop_front() || resp_rdata !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL store resp: got lat %0d err %b rdata %h want lat 3 err 0 rdata 0",
               lat, resp_error, resp_rdata);
    end
    finish_resp();
    checked_txn("load_after_store", 1'b0, 16'h0010, 16'h0, 0);
  endtask

  task automatic test_errors();
    checked_txn("misaligned_load", 1'b0, 16'h0011, 16'h0, 0);
    checked_txn("load_after_misaligned", 1'b0, 16'h0010, 16'h0, 0);
    checked_txn("out_of_range_store", 1'b1, 16'h0200, 16'hDEAD, 0);
    checked_txn("load_word0", 1'b0, 16'h0000, 16'h0, 0);
  endtask

  task automatic test_resp_hold();
    logic to; int lat;
    send_req(1'b0, 16'h0010, 16'h0);
    wait_resp(0, lat, to);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 16'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if (to || resp_valid !== 1'b1 || resp_rdata !== 16'hBEEF || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL resp_hold cycle %0d: got valid %b rdata %h req_ready %b want 1 beef 0",
                 i, resp_valid, resp_rdata, req_ready);
      end
    end
    req_valid = 1'b0;
    finish_resp();
    n_checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 16'h0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL resp_hold release: got valid %b rdata %h busy %b req_ready %b want 0 0 0 1",
               resp_valid, resp_rdata, busy, req_ready);
    end
    checked_txn("hold_no_store", 1'b0, 16'h0010, 16'h0, 0);
  endtask

  task automatic test_stall();
    logic [15:0] a, d;
    a = 16'($urandom_range(0, 15) * 2);
    d = 16'($urandom);
    checked_txn("stall_store", 1'b1, a, d, 3);
    checked_txn("stall_load", 1'b0, a, 16'h0, 3);
  endtask

  task automatic test_reset_mid_wait();
    checked_txn("prior_store", 1'b1, 16'h0004, 16'h5A5A, 0);
    send_req(1'b1, 16'h0004, 16'h1234);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 16'h0 || resp_error !== 1'b0 ||
        busy !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_wait outputs: got valid %b rdata %h err %b busy %b ready %b want all 0",
               resp_valid, resp_rdata, resp_error, busy, req_ready);
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checked_txn("load_after_abort", 1'b0, 16'h0004, 16'h0, 0);
  endtask

  task automatic test_random();
    logic wr; logic [15:0] a; int sel;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 9);
      wr  = 1'($urandom_range(0, 1));
      if (sel < 7)       a = 16'($urandom_range(0, 15) * 2);
      else if (sel == 7) a = 16'($urandom_range(0, 15) * 2 + 1);
      else               a = 16'($urandom_range(DEPTH, 32767) * 2 + (sel - 8));
      checked_txn("random", wr, a, 16'($urandom), 0);
    end
  endtask

  task automatic test_zero_wait();
    logic [15:0] d;
    d = 16'($urandom);
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 16'h0002; z_req_wdata = d;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    n_checks++;
    if (z_resp_valid !== 1'b1 || z_resp_error !== 1'b0 || z_resp_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL zero_wait store: got valid %b err %b rdata %h want 1 0 0",
               z_resp_valid, z_resp_error, z_resp_rdata);
    end
    z_resp_ready = 1'b1; @(posedge clk); #1; z_resp_ready = 1'b0;
    z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 16'h0002;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    n_checks++;
    if (z_resp_valid !== 1'b1 || z_resp_rdata !== d) begin
      n_fail++;
      $display("FAIL zero_wait load: got valid %b rdata %h want 1 %h", z_resp_valid, z_resp_rdata, d);
    end
    z_resp_ready = 1'b1; @(posedge clk); #1; z_resp_ready = 1'b0;
    n_checks++;
    if (z_busy !== 1'b0 || z_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_wait release: got busy %b valid %b want 0 0", z_busy, z_resp_valid);
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_store_load();
    test_errors();
    test_resp_hold();
    test_stall();
    test_reset_mid_wait();
    test_random();
    test_zero_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
